// File: rtl/accum_alu_seq_if.sv
// Request/response bundle between a sequencing controller and the accumulator ALU.
interface accum_alu_seq_if #(
    parameter int DATA_W = 4
);
    logic [DATA_W-1:0]   Data;
    logic [2:0]          Function;
    logic                Valid;
    logic                Ready;
    logic [2*DATA_W-1:0] ALUout;
    logic                Done;
    logic                Flag;

    modport master (
        output Data, Function, Valid,
        input  Ready, ALUout, Done, Flag
    );

    modport slave (
        input  Data, Function, Valid,
        output Ready, ALUout, Done, Flag
    );
endinterface

// File: rtl/accum_alu_seq.sv
// Accumulator ALU: operand A is the low half of the registered result; MUL runs as a
// DATA_W-cycle shift-add loop while the other seven ops complete in one edge.
module accum_alu_seq #(
    parameter int DATA_W = 4
) (
    input logic            Clock,
    input logic            Reset_b,
    accum_alu_seq_if.slave bus
);
    localparam int RW = 2 * DATA_W;
    localparam int CW = $clog2(DATA_W + 1);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] MUL_RUN = 1'b1;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_MUL  = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_HOLD = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_AND  = 3'd5;
    localparam logic [2:0] OP_OR   = 3'd6;

    localparam logic [CW-1:0]     CNT_INIT = CW'(DATA_W);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [DATA_W:0]   SHL_LIM  = (DATA_W + 1)'(RW);

    logic [0:0]        r_state;
    logic [RW-1:0]     r_aluout;
    logic              r_flag;
    logic              r_done;
    logic [RW-1:0]     r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [RW-1:0]     r_prod;
    logic [CW-1:0]     r_count;

    logic [DATA_W-1:0] w_a;
    logic [RW-1:0]     w_aext;
    logic [RW-1:0]     w_bext;
    logic [2*RW-1:0]   w_shl;
    logic [RW-1:0]     w_res;
    logic              w_flag;
    logic [RW-1:0]     w_pp_nxt;

    assign w_a      = r_aluout[DATA_W-1:0];
    assign w_aext   = {{DATA_W{1'b0}}, w_a};
    assign w_bext   = {{DATA_W{1'b0}}, bus.Data};
    // Shifting in double the result width keeps every bit that falls off the top.
    assign w_shl    = {{RW{1'b0}}, w_aext} << bus.Data;
    assign w_pp_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_res  = '0;
        w_flag = 1'b0;
        case (bus.Function)
            OP_ADD: begin
                w_res  = w_aext + w_bext;
                w_flag = |w_res[RW-1:DATA_W];
            end
            OP_SHL: begin
                if ({1'b0, bus.Data} >= SHL_LIM) begin
                    w_res  = '0;
                    w_flag = |w_a;
                end else begin
                    w_res  = w_shl[RW-1:0];
                    w_flag = |w_shl[2*RW-1:RW];
                end
            end
            OP_HOLD: w_res = w_aext;
            OP_SUB: begin
                w_res  = w_aext - w_bext;
                w_flag = (w_a < bus.Data);
            end
            OP_AND:  w_res = w_aext & w_bext;
            OP_OR:   w_res = w_aext | w_bext;
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            r_state  <= IDLE;
            r_aluout <= '0;
            r_flag   <= 1'b0;
            r_done   <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_count  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.Valid) begin
                        if (bus.Function == OP_MUL) begin
                            r_mcand  <= w_aext;
                            r_mplier <= bus.Data;
                            r_prod   <= '0;
                            r_count  <= CNT_INIT;
                            r_state  <= MUL_RUN;
                        end else begin
                            r_aluout <= w_res;
                            r_flag   <= w_flag;
                            r_done   <= 1'b1;
                        end
                    end
                end
                MUL_RUN: begin
                    r_prod   <= w_pp_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count - CNT_ONE;
                    // Last step: publish the product in the same edge the count hits zero.
                    if (r_count == CNT_ONE) begin
                        r_aluout <= w_pp_nxt;
                        r_flag   <= |w_pp_nxt[RW-1:DATA_W];
                        r_done   <= 1'b1;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.Ready  = (r_state == IDLE);
    assign bus.ALUout = r_aluout;
    assign bus.Done   = r_done;
    assign bus.Flag   = r_flag;
endmodule

// File: tb/tb_accum_alu_seq.sv
// Directed bench for accum_alu_seq at DATA_W=4: a table of single-cycle ops plus
// hand-written MUL, mid-run Valid and reset-during-MUL sequences.
module tb_accum_alu_seq;
    localparam int W = 4;

    localparam logic [2:0] ADD = 3'd0, MUL = 3'd1, SHL = 3'd2, HOLD = 3'd3;
    localparam logic [2:0] SUB = 3'd4, ANDO = 3'd5, ORO = 3'd6, CLR = 3'd7;

    typedef struct {
        logic [2:0]     fn;
        logic [W-1:0]   data;
        logic [2*W-1:0] exp_out;
        logic           exp_flag;
    } vec_t;

    logic Clock;
    logic Reset_b;
    int   n_cmp;
    int   n_bad;

    accum_alu_seq_if #(.DATA_W(W)) bus ();

    accum_alu_seq #(.DATA_W(W)) dut (
        .Clock   (Clock),
        .Reset_b (Reset_b),
        .bus     (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk_idle_state(input string name, input logic [2*W-1:0] out, input logic flg);
        chk({name, ".out"},   32'(bus.ALUout), 32'(out));
        chk({name, ".flag"},  32'(bus.Flag),   32'(flg));
        chk({name, ".done"},  32'(bus.Done),   32'd1);
        chk({name, ".ready"}, 32'(bus.Ready),  32'd1);
    endtask

    task automatic do_op(input logic [2:0] fn, input logic [W-1:0] d);
        bus.Valid    = 1'b1;
        bus.Function = fn;
        bus.Data     = d;
        tick();
        bus.Valid    = 1'b0;
    endtask

    vec_t vecs[$];

    initial begin
        int cyc;
        bit seen_done;
        n_cmp = 0;
        n_bad = 0;
        bus.Valid    = 1'b0;
        bus.Function = 3'd0;
        bus.Data     = '0;

        // Reset, checked while asserted and after release
        Reset_b = 1'b0;
        #12;
        chk("rst_on.out",   32'(bus.ALUout), 32'h00);
        chk("rst_on.flag",  32'(bus.Flag),   32'd0);
        chk("rst_on.done",  32'(bus.Done),   32'd0);
        chk("rst_on.ready", 32'(bus.Ready),  32'd1);
        tick();
        Reset_b = 1'b1;
        tick();
        chk("rst_off.out",   32'(bus.ALUout), 32'h00);
        chk("rst_off.flag",  32'(bus.Flag),   32'd0);
        chk("rst_off.done",  32'(bus.Done),   32'd0);
        chk("rst_off.ready", 32'(bus.Ready),  32'd1);

        // Single-cycle ops, applied back to back with Valid held high
        vecs.push_back('{ADD,  4'h9, 8'h09, 1'b0});
        vecs.push_back('{ADD,  4'h9, 8'h12, 1'b1});
        vecs.push_back('{HOLD, 4'h7, 8'h02, 1'b0});
        vecs.push_back('{SUB,  4'h5, 8'hFD, 1'b1});
        vecs.push_back('{CLR,  4'h3, 8'h00, 1'b0});
        vecs.push_back('{ADD,  4'h1, 8'h01, 1'b0});
        vecs.push_back('{SHL,  4'h8, 8'h00, 1'b1});
        vecs.push_back('{CLR,  4'h0, 8'h00, 1'b0});
        vecs.push_back('{SHL,  4'hF, 8'h00, 1'b0});
        vecs.push_back('{ADD,  4'h1, 8'h01, 1'b0});
        vecs.push_back('{SHL,  4'h3, 8'h08, 1'b0});
        vecs.push_back('{CLR,  4'h0, 8'h00, 1'b0});
        vecs.push_back('{ADD,  4'h3, 8'h03, 1'b0});
        vecs.push_back('{SHL,  4'h7, 8'h80, 1'b1});
        vecs.push_back('{CLR,  4'h0, 8'h00, 1'b0});
        vecs.push_back('{ADD,  4'h3, 8'h03, 1'b0});
        vecs.push_back('{SUB,  4'h5, 8'hFE, 1'b1});
        vecs.push_back('{CLR,  4'h0, 8'h00, 1'b0});
        vecs.push_back('{ADD,  4'hC, 8'h0C, 1'b0});
        vecs.push_back('{ANDO, 4'hA, 8'h08, 1'b0});
        vecs.push_back('{ORO,  4'h3, 8'h0B, 1'b0});
        vecs.push_back('{ADD,  4'hF, 8'h1A, 1'b1});
        vecs.push_back('{CLR,  4'h0, 8'h00, 1'b0});
        vecs.push_back('{ADD,  4'hF, 8'h0F, 1'b0});

        bus.Valid = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            bus.Function = vecs[i].fn;
            bus.Data     = vecs[i].data;
            tick();
            chk_idle_state($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_flag);
        end
        bus.Valid = 1'b0;
        tick();
        chk("idle.done", 32'(bus.Done), 32'd0);

        // MUL 0xF * 0xF with a Valid pulse while busy
        do_op(MUL, 4'hF);
        for (int i = 0; i < W; i++) begin
            chk($sformatf("mul.busy%0d.ready", i), 32'(bus.Ready),  32'd0);
            chk($sformatf("mul.busy%0d.out", i),   32'(bus.ALUout), 32'h0F);
            chk($sformatf("mul.busy%0d.done", i),  32'(bus.Done),   32'd0);
            if (i == 1) begin
                bus.Valid    = 1'b1;
                bus.Function = ADD;
                bus.Data     = 4'h1;
            end
            if (i == 2) bus.Valid = 1'b0;
            tick();
        end
        chk_idle_state("mul.end", 8'hE1, 1'b1);
        tick();
        chk("mul.after.done", 32'(bus.Done),   32'd0);
        chk("mul.after.out",  32'(bus.ALUout), 32'hE1);

        // Reset asserted in the middle of a MUL
        do_op(CLR, 4'h0);
        do_op(ADD, 4'h7);
        do_op(MUL, 4'h6);
        tick();
        tick();
        Reset_b = 1'b0;
        #1;
        chk("rstmul.out",   32'(bus.ALUout), 32'h00);
        chk("rstmul.ready", 32'(bus.Ready),  32'd1);
        chk("rstmul.done",  32'(bus.Done),   32'd0);
        chk("rstmul.flag",  32'(bus.Flag),   32'd0);
        tick();
        Reset_b = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.Done) seen_done = 1'b1;
            chk($sformatf("rstmul.post%0d.ready", i), 32'(bus.Ready), 32'd1);
        end
        chk("rstmul.no_done", 32'(seen_done), 32'd0);

        // Fresh MUL after reset: A=0 so product is 0, Done after W busy cycles
        do_op(MUL, 4'h6);
        cyc = 0;
        while (!bus.Done && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("mul0.latency", 32'(cyc), 32'(W));
        chk_idle_state("mul0.end", 8'h00, 1'b0);

        // Back-to-back: ADD accepted in the Done cycle of a MUL sees the product as A
        do_op(ADD, 4'h3);
        do_op(MUL, 4'h5);
        cyc = 0;
        while (!bus.Done && cyc < 20) begin
            tick();
            cyc++;
        end
        chk_idle_state("mul35.end", 8'h0F, 1'b0);
        do_op(ADD, 4'h2);
        chk_idle_state("b2b.add", 8'h11, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/accum_alu_seq.md
# accum_alu_seq

Parametrised sequential accumulator ALU, the successor of the 4-bit/4-function accumulator ALU in the lab datapath. It keeps the accumulate-on-low-half model: operand A is always the low half of the registered result. It generalises the data width and extends the function set to eight operations, one of which is an iterative multi-cycle shift-add multiply. A valid/ready handshake with a completion pulse lets a controller FSM sequence operations.

## Interface
- DATA_W, default 4: operand width; accumulator/result width is 2*DATA_W; legal range 2..16.
- Clock  in  1  rising-edge clock, single domain.
- Reset_b  in  1  asynchronous, active-low reset; clears all state immediately, released synchronously by the driver.
- Data  in  DATA_W  operand B.
- Function  in  3  op code, sampled on acceptance.
- Valid  in  1  request; an op is accepted on a rising edge where Valid && Ready.
- Ready  out  1  high when able to accept.
- ALUout  out  2*DATA_W  registered result; A = ALUout[DATA_W-1:0].
- Done  out  1  one-cycle pulse, coincident with the first cycle ALUout shows a new result.
- Flag  out  1  registered status of the last completed op; meaning per op below.

## Operation
- A and B are unsigned. Results are computed in 2*DATA_W bits and zero-extended.
- 0 ADD: A+B; Flag = 1 if the result's upper half is nonzero.
- 1 MUL: A*B, iterative over DATA_W cycles; Flag = upper half nonzero.
- 2 SHL: A<<B truncated to 2*DATA_W; Flag = 1 if any 1 bit was shifted beyond bit 2*DATA_W-1. B >= 2*DATA_W with A != 0 gives result 0 and Flag 1.
- 3 HOLD: {0, A}; Flag = 0.
- 4 SUB: (A-B) mod 2^(2*DATA_W), i.e. two's-complement wrap; Flag = borrow (A<B).
- 5 AND: {0, A&B}; Flag = 0.
- 6 OR: {0, A|B}; Flag = 0.
- 7 CLEAR: result 0; Flag = 0.
- FSM states: IDLE and MUL_RUN.
- IDLE: Ready=1.
  - A non-MUL op accepted: ALUout and Flag load at that edge, Done=1 next cycle, stay in IDLE.
  - MUL accepted: latch A and B into internal multiplicand and multiplier registers, clear the partial product, set count=DATA_W, go to MUL_RUN.
- MUL_RUN: Ready=0. Each cycle, if the multiplier LSB is 1, add the shifted multiplicand to the partial product. Then shift the multiplicand left, shift the multiplier right, and decrement count.
  - The edge where count reaches 0 writes the product to ALUout, updates Flag, returns to IDLE and makes Done=1.
  - ALUout and Flag keep their previous values throughout MUL_RUN.
- Valid while Ready=0 is ignored. The op is not queued; the requester must hold it.
- Function and Data are sampled only at acceptance. Changes during MUL_RUN have no effect.
- Back-to-back: in the Done cycle after any op Ready=1, so a new op is accepted that cycle and its A is the just-written result.
- Reset, asserted at any time including mid-MUL:
  - ALUout=0, Flag=0, Done=0, Ready=1, state IDLE.
  - The in-flight MUL is discarded and no Done is issued.

## Timing
- Non-MUL latency: 1 edge. The result is visible and Done high in the cycle after acceptance. Throughput is 1 op/cycle.
- MUL latency: DATA_W edges after acceptance. Ready is low for exactly DATA_W cycles. Done and Ready=1 occur together in the cycle after the final edge.
- Done is never high for two consecutive cycles except for consecutive accepted non-MUL ops.
- Ready, Done, ALUout and Flag are all registered or decoded from state only, with no combinational path from inputs.
- Multiplier step counter width: $clog2(DATA_W+1).

## Test plan
- Reset with DATA_W=4, checked both during and after Reset_b low: ALUout=0x00, Flag=0, Done=0, Ready=1.
- ADD chain:
  - Data=9 (A=0): ALUout=0x09, Flag=0.
  - Data=9 again: ALUout=0x12, Flag=1.
  - Done pulses once per op with Valid held high.
- MUL: A=0xF, Data=0xF.
  - Ready low for 4 cycles, ALUout unchanged until completion.
  - Then ALUout=0xE1, Flag=1, Done high for 1 cycle.
  - A Valid pulse mid-run is ignored.
- SHL and SUB:
  - A=1, SHL Data=8: ALUout=0x00, Flag=1.
  - A=1, SHL Data=3: ALUout=0x08, Flag=0.
  - A=3, SUB Data=5: ALUout=0xFE, Flag=1.
- Reset mid-MUL: start MUL with A=7, Data=6, assert Reset_b after cycle 2.
  - ALUout=0 immediately and no Done pulse.
  - Ready=1 after release.
  - A fresh MUL then yields 0x00 (A=0).
- Logic and clear: A=0xC.
  - AND Data=0xA: ALUout=0x08.
  - OR Data=0x3: ALUout=0x0B.
  - CLEAR: ALUout=0x00, Flag=0.
